// File: rtl/ps2_host_tx_if.sv
// Command handshake between the mouse controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, tx_valid, input tx_ready, tx_busy, tx_done, tx_err);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
// Optional ps2_clk glitch filter enabled by defining PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);
  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic [TW-1:0]   to_q, to_d, to_inc;
  logic [3:0]      k_q, k_d;
  logic            bit_oe_q, bit_oe_d;
  logic            timeout;

  logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q, edge_prev_q;
  logic clk_src, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data_i;
      dat_sync_q <= dat_meta_q;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  logic          filt_q;
  logic [FW-1:0] fcnt_q;

  // Filtered level follows the synced clock only after FILTER_LEN consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (clk_sync_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= clk_sync_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign clk_src = filt_q;
`else
  assign clk_src = clk_sync_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_prev_q <= 1'b1;
    else        edge_prev_q <= clk_src;
  end

  assign fall = edge_prev_q & ~clk_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      inh_q    <= '0;
      to_q     <= '0;
      k_q      <= '0;
      bit_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      inh_q    <= inh_d;
      to_q     <= to_d;
      k_q      <= k_d;
      bit_oe_q <= bit_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    par_d       = par_q;
    inh_d       = inh_q;
    to_d        = to_q;
    k_d         = k_q;
    bit_oe_d    = bit_oe_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx.tx_ready = 1'b0;
    tx.tx_done  = 1'b0;
    tx.tx_err   = 1'b0;
    timeout     = (to_q >= TW'(TIMEOUT_CYCLES - 1));
    to_inc      = (to_q == TW'(TIMEOUT_CYCLES)) ? to_q : to_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        tx.tx_ready = 1'b1;
        if (tx.tx_valid) begin
          data_d  = tx.tx_data;
          par_d   = ~^tx.tx_data;
          inh_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          ps2_data_oe = 1'b1;
          state_d     = S_REQ;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_REQ: begin
        ps2_data_oe = 1'b1;
        to_d        = '0;
        k_d         = '0;
        bit_oe_d    = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        ps2_data_oe = bit_oe_q;
        to_d        = to_inc;
        // k_q holds edges already seen; this edge is k_q+1.
        if (timeout) begin
          state_d = S_ERR;
        end else if (fall) begin
          k_d = k_q + 1'b1;
          if (k_q < 4'd8) begin
            bit_oe_d = ~data_q[k_q[2:0]];
          end else if (k_q == 4'd8) begin
            bit_oe_d = ~par_q;
          end else begin
            bit_oe_d = 1'b0;
            state_d  = S_ACK;
          end
        end
      end
      S_ACK: begin
        to_d = to_inc;
        if (timeout)   state_d = S_ERR;
        else if (fall) state_d = dat_sync_q ? S_ERR : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        to_d = to_inc;
        if (timeout)                       state_d = S_ERR;
        else if (clk_sync_q && dat_sync_q) state_d = S_DONE;
      end
      S_DONE: begin
        tx.tx_done = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        tx.tx_err = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx.tx_busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-collector PS/2 device model.
module tb_ps2_host_tx;
  localparam int unsigned INH  = 50;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned FL   = 8;
  localparam int unsigned HALF = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_oe, data_oe;
  logic clk_line, data_line;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;
  int done_cnt = 0, err_cnt = 0, inh_run = 0, inh_last = 0;
  int unsigned req_cyc;

  ps2_host_tx_if txif ();

  assign clk_line  = ~(clk_oe | dev_clk_low);
  assign data_line = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx          (txif),
    .ps2_clk_i   (clk_line),
    .ps2_data_i  (data_line),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (txif.tx_done) done_cnt <= done_cnt + 1;
    if (txif.tx_err)  err_cnt  <= err_cnt + 1;
    if (clk_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin
      inh_last <= inh_run;
      inh_run  <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    chk("ready_before_accept", txif.tx_ready, 1);
    txif.tx_data  = b;
    txif.tx_valid = 1'b1;
    @(negedge clk);
    txif.tx_valid = 1'b0;
    chk("busy_after_accept", txif.tx_busy, 1);
    chk("ready_after_accept", txif.tx_ready, 0);
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < int'(INH) + 20 && !ok; i++) begin
      @(negedge clk);
      if (!clk_oe && data_oe) ok = 1'b1;
    end
    req_cyc = cyc;
    chk("req_seen", ok, 1);
  endtask

  task automatic pulse(input bit glitch, output logic smp);
    dev_clk_low = 1'b1;
    cycles(HALF);
    dev_clk_low = 1'b0;
    smp = data_line;
    if (glitch) begin
      cycles(6);
      dev_clk_low = 1'b1;
      cycles(3);
      dev_clk_low = 1'b0;
      cycles(HALF - 9);
    end else begin
      cycles(HALF);
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (txif.tx_done) ok = 1'b1;
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic run_frame(input logic [7:0] b, input logic exp_par, input int glitch_at,
                           input bit noise);
    logic [9:0] bits;
    logic smp;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(b);
    wait_req();
    cycles(10);
    if (noise) begin
      txif.tx_data  = 8'h00;
      txif.tx_valid = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      pulse(i == glitch_at, smp);
      bits[i] = smp;
    end
    txif.tx_valid = 1'b0;
    chk("frame_bits", {22'd0, bits}, {22'd0, 1'b1, exp_par, b});
    chk("busy_in_frame", txif.tx_busy, 1);
    dev_data_low = 1'b1;
    cycles(5);
    dev_clk_low = 1'b1;
    cycles(HALF);
    dev_clk_low = 1'b0;
    cycles(5);
    dev_data_low = 1'b0;
    wait_done();
    cycles(2);
    chk("done_once", done_cnt, d0 + 1);
    chk("no_err_in_frame", err_cnt, e0);
    chk("inhibit_len", inh_last, INH);
    chk("ready_after_done", txif.tx_ready, 1);
    chk("lines_released", {clk_oe, data_oe}, 2'b00);
  endtask

  initial begin
    logic [9:0] bits;
    logic smp;
    bit ok;
    int d0, e0;
    int unsigned delta;

    txif.tx_data  = 8'h00;
    txif.tx_valid = 1'b0;

    // Reset state
    cycles(3);
    chk("rst_ready", txif.tx_ready, 1);
    chk("rst_busy", txif.tx_busy, 0);
    chk("rst_oe", {clk_oe, data_oe}, 2'b00);
    chk("rst_pulses", {txif.tx_done, txif.tx_err}, 2'b00);
    rst_n = 1'b1;
    cycles(2);
    chk("post_rst_ready", txif.tx_ready, 1);

    // Device traffic while idle is ignored
    dev_data_low = 1'b1;
    for (int i = 0; i < 3; i++) pulse(1'b0, smp);
    dev_data_low = 1'b0;
    cycles(4);
    chk("idle_traffic_busy", txif.tx_busy, 0);
    chk("idle_traffic_oe", {clk_oe, data_oe}, 2'b00);
    chk("idle_traffic_pulses", done_cnt + err_cnt, 0);

    // Enable reporting, with ignored tx_valid during the frame
    run_frame(8'hF4, 1'b0, -1, 1'b1);
    run_frame(8'hFF, 1'b1, -1, 1'b0);
    run_frame(8'h00, 1'b1, -1, 1'b0);

    // Missing ACK
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'hF3);
    wait_req();
    cycles(10);
    for (int i = 0; i < 10; i++) begin
      pulse(1'b0, smp);
      bits[i] = smp;
    end
    chk("noack_bits", {22'd0, bits}, {22'd0, 1'b1, 1'b1, 8'hF3});
    dev_clk_low = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < int'(HALF) && !ok; i++) begin
      @(negedge clk);
      if (txif.tx_err) ok = 1'b1;
    end
    chk("noack_err_seen", ok, 1);
    chk("noack_oe_in_err", {clk_oe, data_oe}, 2'b00);
    @(negedge clk);
    chk("noack_err_one_cycle", txif.tx_err, 0);
    chk("noack_ready_next", txif.tx_ready, 1);
    chk("noack_oe_next", {clk_oe, data_oe}, 2'b00);
    dev_clk_low = 1'b0;
    cycles(HALF);
    chk("noack_err_cnt", err_cnt, e0 + 1);
    chk("noack_no_done", done_cnt, d0);

    // Timeout: device never clocks after the request-to-send
    e0 = err_cnt;
    send_cmd(8'hF4);
    wait_req();
    @(negedge clk);
    chk("tmo_start_bit_driven", {clk_oe, data_oe}, 2'b01);
    ok = 1'b0;
    for (int i = 0; i < int'(TMO) + 50 && !ok; i++) begin
      @(negedge clk);
      if (txif.tx_err) ok = 1'b1;
    end
    delta = cyc - req_cyc;
    chk("tmo_err_seen", ok, 1);
    chk("tmo_delta", (delta >= TMO - 1 && delta <= TMO + 1) ? TMO : delta, TMO);
    chk("tmo_oe_released", {clk_oe, data_oe}, 2'b00);
    cycles(2);
    chk("tmo_err_cnt", err_cnt, e0 + 1);

    // Reset during k=5 of SEND
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'h00);
    wait_req();
    cycles(10);
    for (int i = 0; i < 4; i++) pulse(1'b0, smp);
    dev_clk_low = 1'b1;
    cycles(8);
    chk("k5_data_driven", {clk_oe, data_oe}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", {clk_oe, data_oe}, 2'b00);
    chk("midrst_ready_busy", {txif.tx_ready, txif.tx_busy}, 2'b10);
    dev_clk_low = 1'b0;
    cycles(5);
    rst_n = 1'b1;
    cycles(3);
    chk("midrst_no_pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);
    run_frame(8'hF4, 1'b0, -1, 1'b0);

`ifdef PS2_TX_GLITCH_FILTER_EN
    run_frame(8'hF4, 1'b0, 3, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter: the sending counterpart to the existing mouse receive path.
- Sends single command bytes to the mouse (0xF4 enable reporting, 0xFF reset, 0xF3 set sample rate) over the shared open-collector ps2_clk/ps2_data lines.
- Runs in the 100 MHz clk domain beside the mouse controller.
- Top level converts the *_oe outputs to tri-states: oe=1 drives 0, oe=0 releases to Z.

Parameters:
- INHIBIT_CYCLES, 10000: cycles ps2_clk is held low before the request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum cycles from request-to-send until the ACK and line-idle check complete (15 ms).
- FILTER_LEN, 8: glitch filter depth in cycles; used only with PS2_TX_GLITCH_FILTER_EN.

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  command request
- tx_ready  out  1  high when IDLE; byte accepted when tx_valid && tx_ready
- tx_busy  out  1  high in every state except IDLE; the receiver ignores frames while it is high
- tx_done  out  1  one-cycle pulse: byte sent and ACKed
- tx_err  out  1  one-cycle pulse: timeout or missing ACK
- ps2_clk_i  in  1  raw ps2_clk pin level (asynchronous)
- ps2_data_i  in  1  raw ps2_data pin level (asynchronous)
- ps2_clk_oe  out  1  1 = pull ps2_clk low
- ps2_data_oe  out  1  1 = pull ps2_data low

Behaviour:
Reset and input synchronisation:
- While rst_n=0, asynchronously: state=IDLE, both oe=0, tx_done=tx_err=0, tx_busy=0, tx_ready=1, counters cleared.
- Reset mid-frame releases both lines immediately. No done or error pulse is issued.
- ps2_clk_i and ps2_data_i each pass through a 2-FF synchroniser.
- Falling edge = previous synced clock 1 and current 0. Edge detect latency is 3 cycles after the pin changes.

Accept:
- In IDLE, tx_valid && tx_ready latches tx_data.
- Odd parity is computed: parity = ~^tx_data.
- Next state is INHIBIT. tx_valid outside IDLE is ignored.

FSM:
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. ps2_data_oe goes to 1 on the last of these cycles. Then go to REQ.
- REQ: ps2_clk_oe=0, ps2_data_oe=1 (this low data is the start bit). Clear the timeout counter and edge counter. Go to SEND.
- SEND: act on each falling edge of the synced clock, counted as k=1..10.
  - k=1..8: drive tx_data[k-1], LSB first (ps2_data_oe = ~bit).
  - k=9: drive parity.
  - k=10: release data (stop bit), then go to ACK.
- ACK: on the next falling edge, sample synced data.
  - 0: go to WAIT_IDLE.
  - 1: go to ERR.
- WAIT_IDLE: both oe=0. When synced clk=1 and data=1 in the same cycle, go to DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- ERR: both oe=0, tx_err=1 for one cycle, then IDLE.

Timeout and boundaries:
- The timeout counter runs in SEND, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES goes to ERR from any of these states.
- The counter saturates and never wraps. Timeout takes priority over a same-cycle clock edge.
- Device-originated traffic while IDLE is ignored; both lines stay released.

Optional Feature:
- Macro: PS2_TX_GLITCH_FILTER_EN.
- When defined: the synced ps2_clk feeds a filter. The filtered value changes only after the raw synced value has differed from it for FILTER_LEN consecutive cycles. Edge detection uses the filtered value, adding FILTER_LEN cycles of latency. A low pulse shorter than FILTER_LEN cycles produces no edge.
- When undefined: edges come directly from the 2-FF synchronised clock. The filter logic and FILTER_LEN are unused.

Test Plan:
- Reset, then send 0xF4 to a bench device model that ACKs.
  - ps2_clk_oe is high for exactly INHIBIT_CYCLES.
  - Data bits observed on device rising edges are 0,0,1,0,1,1,1,1, then parity 0, stop 1.
  - tx_done pulses once; tx_err stays 0.
- Send 0xFF, then 0x00. Parity bit is 1 in both cases, and both complete with tx_done.
- Device model does not ACK (data high at the 11th falling edge): tx_err pulses one cycle, both oe=0, tx_ready=1 on the following cycle.
- TIMEOUT_CYCLES=2000, device never clocks after REQ: tx_err at cycle 2000 ±1 after REQ entry, and both lines are released.
- Assert rst_n low during k=5 of SEND: both oe drop in the same cycle, no tx_done or tx_err pulse. A new 0xF4 after reset completes normally.
- With PS2_TX_GLITCH_FILTER_EN, inject a 3-cycle low glitch on ps2_clk during SEND: the bit index does not advance and the frame still completes correctly.
